// File: rtl/lock_pkg.sv
// Shared definitions for the number-lock input conditioning stage.
// Holds the one-hot channel state encodings, their bit positions, the
// default stability counter widths and a small output decode helper.
package lock_pkg;

  // One-hot channel states (legacy-compatible plain constants)
  localparam logic [4:0] INI  = 5'b00001;
  localparam logic [4:0] WQ   = 5'b00010;
  localparam logic [4:0] SCEN = 5'b00100;
  localparam logic [4:0] HELD = 5'b01000;
  localparam logic [4:0] WFQ  = 5'b10000;

  // Bit positions inside the one-hot state vector
  localparam int INI_BIT  = 0;
  localparam int WQ_BIT   = 1;
  localparam int SCEN_BIT = 2;
  localparam int HELD_BIT = 3;
  localparam int WFQ_BIT  = 4;

  // Stability counter widths: short for simulation, ~10 ms at 100 MHz on the board
  localparam int N_DC_SIM   = 4;
  localparam int N_DC_BOARD = 20;

  // The debounced level is high in every state from the accept strobe up to
  // the end of release qualification, so release bounce never drops it.
  function automatic logic dbFromState(input logic [4:0] state);
    return state[SCEN_BIT] | state[HELD_BIT] | state[WFQ_BIT];
  endfunction

endpackage

// File: rtl/lock_db_channel.sv
// One debounce channel: a Moore FSM with an N_DC-bit stability counter.
// An input level has to be seen unchanged for 2^N_DC consecutive clocks
// before it is accepted. Outputs are decoded purely from the one-hot state
// register, so they never glitch and never follow the raw input directly.
module lock_db_channel
  import lock_pkg::*;
#(
  parameter int N_DC = N_DC_SIM
) (
  input  logic Clk,
  input  logic reset,
  input  logic s_in,
  output logic db_out,
  output logic pulse_out
);

  // Terminal count: reaching it always forces a state exit, so the counter never wraps
  localparam logic [N_DC-1:0] CNT_MAX = '1;

  logic [4:0]      state_q, state_d;
  logic [N_DC-1:0] count_q, count_d;

  // Next-state and counter logic for the press/release qualification FSM
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      INI: begin
        if (s_in) begin
          state_d = WQ;
          count_d = '0;
        end
      end
      WQ: begin
        if (!s_in) begin
          state_d = INI;
        end else if (count_q == CNT_MAX) begin
          state_d = SCEN;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      SCEN: begin
        state_d = HELD;
      end
      HELD: begin
        if (!s_in) begin
          state_d = WFQ;
          count_d = '0;
        end
      end
      WFQ: begin
        if (s_in) begin
          state_d = HELD;
        end else if (count_q == CNT_MAX) begin
          state_d = INI;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = INI;
        count_d = '0;
      end
    endcase
  end

  // State and counter registers; reset returns the channel to INI with outputs low
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= INI;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign db_out    = dbFromState(state_q);
  assign pulse_out = state_q[SCEN_BIT];

endmodule

// File: rtl/lock_input_debouncer.sv
// Input conditioning for the number-lock FSM: two independent debounce
// channels turn the bouncy U and Z pushbutton levels into clean levels
// plus single-clock accept strobes.
// Optional macro LOCK_DB_SYNC_EN: when defined, each raw input first goes
// through a 2-flop synchronizer (reset to 0), adding 2 clocks to every
// press and release latency. When undefined the raw inputs feed the
// channels directly, for simulation or already-synchronized sources.
module lock_input_debouncer
  import lock_pkg::*;
#(
  parameter int N_DC = N_DC_SIM
) (
  input  logic Clk,
  input  logic reset,
  input  logic U_raw,
  input  logic Z_raw,
  output logic U,
  output logic Z,
  output logic U_pulse,
  output logic Z_pulse
);

  logic uSample;
  logic zSample;

`ifdef LOCK_DB_SYNC_EN
  logic [1:0] uSync_q;
  logic [1:0] zSync_q;

  // Two-stage synchronizers bringing the asynchronous button levels into the Clk domain
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      uSync_q <= 2'b00;
      zSync_q <= 2'b00;
    end else begin
      uSync_q <= {uSync_q[0], U_raw};
      zSync_q <= {zSync_q[0], Z_raw};
    end
  end

  assign uSample = uSync_q[1];
  assign zSample = zSync_q[1];
`else
  assign uSample = U_raw;
  assign zSample = Z_raw;
`endif

  lock_db_channel #(
    .N_DC(N_DC)
  ) uChannel (
    .Clk      (Clk),
    .reset    (reset),
    .s_in     (uSample),
    .db_out   (U),
    .pulse_out(U_pulse)
  );

  lock_db_channel #(
    .N_DC(N_DC)
  ) zChannel (
    .Clk      (Clk),
    .reset    (reset),
    .s_in     (zSample),
    .db_out   (Z),
    .pulse_out(Z_pulse)
  );

endmodule
